mgs_result_reader: RTL

MGS_RESULT_READER -- requirements
Module: mgs_result_reader

---
 rtl/mgs_result_reader.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mgs_result_reader.sv
// mgs_result_reader
//   Streams a run of 96-bit words out of one of three result BRAMs (Q, R, U)
//   onto a valid/ready stream. Reads are issued one per cycle into a 4-entry
//   skid FIFO, throttled so the FIFO can always absorb every word in flight.
//
// Ports
//   clk, rst_n               clock, async active-low reset
//   start_rd, sel, base, len readout request (latched in IDLE)
//   q/r/u_addr, q/r/u_rdata  BRAM read ports (RD_LAT-cycle latency)
//   m_data/m_valid/m_ready/m_last  output stream
//   busy, done_rd, err       status; err pulses with done_rd on reject
module mgs_result_reader #(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_rd,
    input  logic [1:0]  sel,
    input  logic [6:0]  base,
    input  logic [7:0]  len,
    output logic [6:0]  q_addr,
    input  logic [95:0] q_rdata,
    output logic [2:0]  r_addr,
    input  logic [95:0] r_rdata,
    output logic [5:0]  u_addr,
    input  logic [95:0] u_rdata,
    output logic [95:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_last,
    output logic        busy,
    output logic        done_rd,
    output logic        err
);

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_READ, S_DRAIN, S_DONE} state_t;

    state_t            r_state, w_next;
    logic [1:0]        r_sel;
    logic [6:0]        r_base;
    logic [7:0]        r_len;
    logic              r_err;
    logic [7:0]        r_issued;
    logic [7:0]        r_popped;
    logic [RD_LAT-1:0] r_vld_pipe;   // one bit per read in flight
    logic [95:0]       r_mem [4];
    logic [1:0]        r_wp, r_rp;
    logic [2:0]        r_cnt;

    logic [7:0]  w_sum;
    logic        w_reject;
    logic [2:0]  w_inflight;
    logic [2:0]  w_occ;
    logic        w_issue;
    logic        w_push;
    logic        w_pop;
    logic [6:0]  w_rd_addr;
    logic [95:0] w_rdata;

    assign w_sum    = {1'b0, r_base} + r_len;
    assign w_reject = (r_sel == 2'b11) ||
                      (r_sel == 2'b00 && w_sum > 8'd128) ||
                      (r_sel == 2'b01 && w_sum > 8'd8) ||
                      (r_sel == 2'b10 && w_sum > 8'd64);

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LAT; i++)
            w_inflight = w_inflight + {2'b00, r_vld_pipe[i]};
    end

    // Words in flight are counted against FIFO space, so a capture never
    // finds the FIFO full even if the consumer stalls indefinitely.
    assign w_occ     = r_cnt + w_inflight;
    assign w_issue   = (r_state == S_READ) && (r_issued != r_len) && (w_occ < 3'd4);
    assign w_push    = r_vld_pipe[RD_LAT-1];
    assign w_pop     = m_valid && m_ready;
    assign w_rd_addr = r_base + r_issued[6:0];

    always_comb begin
        case (r_sel)
            2'b00:   w_rdata = q_rdata;
            2'b01:   w_rdata = r_rdata;
            default: w_rdata = u_rdata;
        endcase
    end

    assign q_addr = (w_issue && r_sel == 2'b00) ? w_rd_addr      : '0;
    assign r_addr = (w_issue && r_sel == 2'b01) ? w_rd_addr[2:0] : '0;
    assign u_addr = (w_issue && r_sel == 2'b10) ? w_rd_addr[5:0] : '0;

    assign m_valid = (r_cnt != 3'd0);
    assign m_data  = m_valid ? r_mem[r_rp] : '0;
    // Pop count only moves on acceptance, so m_last is stable under stall.
    assign m_last  = m_valid && (r_popped == r_len - 8'd1);
    assign busy    = (r_state != S_IDLE);
    assign done_rd = (r_state == S_DONE);
    assign err     = (r_state == S_DONE) && r_err;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start_rd) w_next = S_CHECK;
            S_CHECK: w_next = (w_reject || r_len == 8'd0) ? S_DONE : S_READ;
            S_READ:  if (w_issue && r_issued == r_len - 8'd1) w_next = S_DRAIN;
            S_DRAIN: if (w_pop && m_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_sel      <= '0;
            r_base     <= '0;
            r_len      <= '0;
            r_err      <= 1'b0;
            r_issued   <= '0;
            r_popped   <= '0;
            r_vld_pipe <= '0;
            r_wp       <= '0;
            r_rp       <= '0;
            r_cnt      <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && start_rd) begin
                r_sel    <= sel;
                r_base   <= base;
                r_len    <= len;
                r_err    <= 1'b0;
                r_issued <= '0;
                r_popped <= '0;
            end
            if (r_state == S_CHECK) r_err <= w_reject;
            if (w_issue) r_issued <= r_issued + 8'd1;
            if (w_pop)   r_popped <= r_popped + 8'd1;

            r_vld_pipe[0] <= w_issue;
            for (int i = 1; i < RD_LAT; i++)
                r_vld_pipe[i] <= r_vld_pipe[i-1];

            if (w_push) r_wp <= r_wp + 2'd1;
            if (w_pop)  r_rp <= r_rp + 2'd1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 3'd1;
                2'b01:   r_cnt <= r_cnt - 3'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Payload storage needs no reset: m_data is gated by m_valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= w_rdata;
    end

endmodule
